ofmap_wb: RTL

- Writeback stage directly downstream of the datapath's 8-lane post-scale output (o_data, 8 x 16-bit signed, valid on the delayed wr_pipe strobe).
- Requantizes each lane to a 2-bit unsigned activation and packs the 8 lanes into one 16-bit word.
- Buffers packed words in a small FIFO.
- Writes them to the ofmap memory through a req/ack port with an auto-incrementing address, so results re-enter the activation path in the same 2-bit format as i_acth/i_actv.

---
 rtl/ofmap_wb_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 45 ++++
 rtl/ofmap_wb.sv | 104 ++++++++++
 3 files changed

// File: rtl/ofmap_wb_pkg.sv
// Shared types, widths and the per-lane requantizer for the ofmap writeback stage.
package ofmap_wb_pkg;
    localparam int LANES = 8;
    localparam int IW    = 16;
    localparam int OW    = 2;
    localparam int SAT   = (1 << OW) - 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    // Negative lanes clamp to zero, so the shift only ever sees non-negative values.
    function automatic logic [OW-1:0] requant(input logic signed [IW-1:0] v,
                                              input logic [3:0] sh);
        logic [IW-1:0] r;
        r = IW'(v) >> sh;
        if (v[IW-1])
            return '0;
        else if (r > IW'(SAT))
            return OW'(SAT);
        else
            return r[OW-1:0];
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// Small power-of-two FIFO with synchronous clear; the caller guards push/pop against full/empty.
module sync_fifo #(
    parameter int W  = 16,
    parameter int D  = 4,
    parameter int PW = $clog2(D)
) (
    input  logic          ck,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [PW:0]   count
);
    logic [W-1:0]  mem [D];
    logic [PW-1:0] wr_ptr, rd_ptr;

    always_ff @(posedge ck) begin
        if (push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge ck) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == (PW+1)'(D));
    assign empty = (count == '0);
endmodule

// File: rtl/ofmap_wb.sv
// Requantizes 8-lane post-scale results to 2-bit activations, packs them and writes
// them to ofmap memory over a req/ack port with an auto-incrementing address.
module ofmap_wb
    import ofmap_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 10
) (
    input  logic                ck,
    input  logic                rst,
    input  logic                i_start,
    input  logic [AW-1:0]       i_base_addr,
    input  logic [3:0]          i_shift,
    input  logic                i_flush,
    input  logic                i_valid,
    input  logic [LANES*IW-1:0] i_data,
    output logic                o_mem_req,
    output logic [AW-1:0]       o_mem_addr,
    output logic [LANES*OW-1:0] o_mem_wdata,
    input  logic                i_mem_ack,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_overflow
);
    localparam int PW = $clog2(DEPTH);

    state_t              state, state_n;
    logic [AW-1:0]       addr;
    logic [3:0]          shift;
    logic                pipe_vld;
    logic [LANES*OW-1:0] pipe_data, packed_w, head;
    logic                overflow, done;
    logic                full, empty, accept, push, pop, drop, drain_ok;
    logic [PW:0]         count;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign packed_w[(LANES-1-g)*OW +: OW] =
            requant($signed(i_data[(LANES-1-g)*IW +: IW]), shift);
    end

    assign accept = (state == RUN) && i_valid && !i_start;
    assign pop    = o_mem_req && i_mem_ack;
    // A full FIFO still takes the word when the head leaves in the same cycle.
    assign push   = pipe_vld && (!full || pop);
    assign drop   = pipe_vld && full && !pop;
    assign drain_ok = !pipe_vld && (empty || (count == (PW+1)'(1) && pop));

    sync_fifo #(.W(LANES*OW), .D(DEPTH)) u_fifo (
        .ck    (ck),
        .rst   (rst),
        .clr   (i_start),
        .push  (push),
        .pop   (pop),
        .din   (pipe_data),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        state_n = state;
        case (state)
            RUN:     if (i_flush)  state_n = DRAIN;
            DRAIN:   if (drain_ok) state_n = IDLE;
            default: state_n = state;
        endcase
        if (i_start)
            state_n = RUN;
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            shift     <= '0;
            pipe_vld  <= 1'b0;
            pipe_data <= '0;
            overflow  <= 1'b0;
            done      <= 1'b0;
        end else begin
            state <= state_n;
            done  <= (state == DRAIN) && (state_n == IDLE);
            if (i_start) begin
                addr     <= i_base_addr;
                shift    <= i_shift;
                pipe_vld <= 1'b0;
                overflow <= 1'b0;
            end else begin
                pipe_vld <= accept;
                if (accept) pipe_data <= packed_w;
                if (pop)    addr      <= addr + 1'b1;
                if (drop)   overflow  <= 1'b1;
            end
        end
    end

    assign o_mem_req   = !empty && (state != IDLE);
    assign o_mem_addr  = addr;
    assign o_mem_wdata = o_mem_req ? head : '0;
    assign o_busy      = (state != IDLE);
    assign o_done      = done;
    assign o_overflow  = overflow;
endmodule
